// File: rtl/data_sampling.sv
// UART receiver bit sampler: two-flop line synchroniser plus a three-point
// majority vote around the centre of each oversampled bit.
module data_sampling #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  dat_samp_en,
  output logic                  rx_sync,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  s0_q;
  logic                  s0_d;
  logic                  s1_q;
  logic                  s1_d;
  logic                  bit_q;
  logic                  bit_d;
  logic                  vld_q;
  logic                  vld_d;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The three sample points are always distinct, so even an illegal Prescale
  // yields at most one vote per edge_cnt wrap.
  assign mid    = Prescale >> 1;
  assign mid_m1 = mid - ONE;
  assign mid_p1 = mid + ONE;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    bit_d = bit_q;
    vld_d = 1'b0;
    if (!dat_samp_en) begin
      // Dropping the enable discards any partially collected triple.
      s0_d = 1'b1;
      s1_d = 1'b1;
    end else if (edge_cnt == mid_m1) begin
      s0_d = sync2_q;
    end else if (edge_cnt == mid) begin
      s1_d = sync2_q;
    end else if (edge_cnt == mid_p1) begin
      bit_d = majority3(s0_q, s1_q, sync2_q);
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      bit_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      bit_q <= bit_d;
      vld_q <= vld_d;
    end
  end

  assign rx_sync      = sync2_q;
  assign sampled_bit  = bit_q;
  assign sample_valid = vld_q;

endmodule

// File: tb/tb_data_sampling.sv
// Scoreboard bench for data_sampling: directed scenarios followed by random
// bits, all checked against a line-history majority-vote model.
module tb_data_sampling;

  localparam int PW   = 6;
  localparam int MAXC = 30000;
  localparam int BIG  = 1 << 30;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] edge_cnt;
  logic          dat_samp_en;
  logic          rx_sync;
  logic          sampled_bit;
  logic          sample_valid;

  data_sampling #(.PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .edge_cnt     (edge_cnt),
    .dat_samp_en  (dat_samp_en),
    .rx_sync      (rx_sync),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct { int due; bit b; } exp_t;
  typedef struct { int c; bit b; int ec; } obs_t;

  exp_t expq[$];
  obs_t obsq[$];
  bit   hist_rx [MAXC];
  bit   hist_en [MAXC];
  int   hist_ec [MAXC];
  int   hist_ps [MAXC];
  int   cyc      = 0;
  int   rel_cyc  = BIG;
  bit   last_bit = 1'b1;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   exp_frame [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
  int   sweep_ps  [3]  = '{8, 16, 32};
  int   sweep_ec  [3]  = '{6, 10, 18};

  task automatic check_bit(string name, logic act, logic exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic check_int(string name, int act, int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Line value seen on the synchronised output two cycles after it was driven;
  // anything driven before the last reset release is masked by the reset value 1.
  function automatic bit line_at(int k);
    if (k >= rel_cyc) return hist_rx[k];
    return 1'b1;
  endfunction

  // A bit is voted iff the enable covered all three centre samples since reset;
  // the result is whichever level at least two of those samples saw.
  function automatic void model(int n);
    int mid;
    int ones;
    mid = hist_ps[n] >> 1;
    if (n - 2 >= rel_cyc && hist_en[n] && hist_en[n-1] && hist_en[n-2] &&
        hist_ec[n] == mid + 1 && hist_ec[n-1] == mid && hist_ec[n-2] == mid - 1) begin
      exp_t e;
      ones  = int'(line_at(n-4)) + int'(line_at(n-3)) + int'(line_at(n-2));
      e.due = n + 1;
      e.b   = (ones >= 2);
      expq.push_back(e);
    end
  endfunction

  task automatic step(bit rx, int ec, bit en, int ps);
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    RX_IN       = rx;
    edge_cnt    = PW'(ec);
    dat_samp_en = en;
    Prescale    = PW'(ps);
    hist_rx[cyc] = rx;
    hist_en[cyc] = en;
    hist_ec[cyc] = ec;
    hist_ps[cyc] = ps;
    model(cyc);
  endtask

  task automatic run_bit(int ps, logic [31:0] pat, int en_until);
    for (int e = 0; e < ps; e++) step(pat[e], e, (e < en_until), ps);
  endtask

  task automatic rst_assert();
    #1;
    RST      = 1'b0;
    rel_cyc  = BIG;
    last_bit = 1'b1;
    expq.delete();
  endtask

  task automatic rst_release();
    #1;
    RST     = 1'b1;
    rel_cyc = cyc;
  endtask

  function automatic int last_obs_b();
    if (obsq.size() == 0) return 2;
    return int'(obsq[$].b);
  endfunction

  // Monitor: compares every cycle against the scoreboard and logs pulses.
  bit   mon_exp;
  exp_t mon_e;
  obs_t mon_o;
  always @(negedge CLK) begin
    if (cyc > 0) begin
      check_bit("rx_sync", rx_sync, line_at(cyc - 2));
      mon_exp = (expq.size() > 0) && (expq[0].due == cyc);
      check_bit("sample_valid", sample_valid, mon_exp);
      if (mon_exp) begin
        mon_e    = expq.pop_front();
        last_bit = mon_e.b;
      end
      check_bit("sampled_bit", sampled_bit, last_bit);
      if (sample_valid === 1'b1) begin
        mon_o.c  = cyc;
        mon_o.b  = sampled_bit;
        mon_o.ec = int'(edge_cnt);
        obsq.push_back(mon_o);
      end
    end
  end

  initial begin
    logic [31:0] pat;
    logic [9:0]  fb;
    int          ps;
    int          mode;
    int          en_until;
    bit          bv;

    RST = 1'b1; RX_IN = 1'b0; Prescale = PW'(8); edge_cnt = '0; dat_samp_en = 1'b0;
    #2 RST = 1'b0;

    // Reset with the line low, then release and watch the 2-edge latency.
    repeat (3) step(1'b0, 0, 1'b0, 8);
    check_bit("rst_rx_sync", rx_sync, 1'b1);
    check_bit("rst_sampled_bit", sampled_bit, 1'b1);
    check_bit("rst_sample_valid", sample_valid, 1'b0);
    rst_release();
    step(1'b0, 0, 1'b0, 8);
    check_bit("sync_after_1_edge", rx_sync, 1'b1);
    step(1'b0, 0, 1'b0, 8);
    check_bit("sync_after_2_edges", rx_sync, 1'b0);
    run_bit(8, '1, 0);

    // Frame 0x5A at Prescale 8: start, 8 data bits LSB first, stop.
    obsq.delete();
    fb = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 10; i++) run_bit(8, fb[i] ? '1 : '0, 8);
    check_int("frame_pulses", obsq.size(), 10);
    if (obsq.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check_int("frame_bit", int'(obsq[i].b), exp_frame[i]);
        check_int("frame_valid_ec", obsq[i].ec, 6);
        if (i > 0) check_int("frame_spacing", obsq[i].c - obsq[i-1].c, 8);
      end
    end

    // Glitch rejection at Prescale 16 (RX_IN leads the sampled line by 2).
    pat = '1;
    pat[6] = 1'b0;
    run_bit(16, pat, 16);
    check_int("glitch_single", last_obs_b(), 1);
    pat[7] = 1'b0;
    run_bit(16, pat, 16);
    check_int("glitch_double", last_obs_b(), 0);

    // Prescale sweep: pulse position and spacing.
    for (int i = 0; i < 3; i++) begin
      obsq.delete();
      run_bit(sweep_ps[i], $urandom, sweep_ps[i]);
      run_bit(sweep_ps[i], $urandom, sweep_ps[i]);
      check_int("sweep_pulses", obsq.size(), 2);
      if (obsq.size() == 2) begin
        check_int("sweep_valid_ec0", obsq[0].ec, sweep_ec[i]);
        check_int("sweep_valid_ec1", obsq[1].ec, sweep_ec[i]);
        check_int("sweep_spacing", obsq[1].c - obsq[0].c, sweep_ps[i]);
      end
    end

    // Enable dropped at edge_cnt 8, then re-enabled for the next bit.
    run_bit(16, '1, 16);
    obsq.delete();
    run_bit(16, '0, 8);
    check_int("abort_no_valid", obsq.size(), 0);
    check_bit("abort_hold", sampled_bit, 1'b1);
    run_bit(16, '0, 16);
    check_int("abort_reenable", last_obs_b(), 0);

    // Asynchronous reset at edge_cnt 8 while sampled_bit is 0.
    obsq.delete();
    for (int e = 0; e <= 8; e++) step(1'b0, e, 1'b1, 16);
    rst_assert();
    #1;
    check_bit("rst_mid_rx_sync", rx_sync, 1'b1);
    check_bit("rst_mid_sampled_bit", sampled_bit, 1'b1);
    check_bit("rst_mid_sample_valid", sample_valid, 1'b0);
    step(1'b0, 9, 1'b1, 16);
    step(1'b0, 10, 1'b1, 16);
    rst_release();
    for (int e = 11; e < 16; e++) step(1'b0, e, 1'b1, 16);
    check_int("rst_mid_no_valid", obsq.size(), 0);
    run_bit(16, '0, 16);
    check_int("rst_mid_first_sample", last_obs_b(), 0);

    // Random bits: clean or noisy lines, full/absent/truncated enables.
    ps = 8;
    for (int b = 0; b < 400; b++) begin
      if (b % 8 == 0) ps = sweep_ps[$urandom_range(0, 2)];
      bv = 1'($urandom_range(0, 1));
      pat = ($urandom_range(0, 1) == 1) ? (bv ? '1 : '0) : $urandom;
      mode = $urandom_range(0, 9);
      en_until = (mode < 7) ? ps : (mode < 8) ? 0 : $urandom_range(0, ps - 1);
      run_bit(ps, pat, en_until);
    end

    run_bit(8, '1, 0);
    check_int("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
